// File: rtl/or_in_packer.sv
// rtl/or_in_packer.sv - operand packer and result checker in front of an OR reduction tree
//
// Collects NUMBER_INPUT operand words of BIT bits from a valid/ready stream.
// When the last word of a frame arrives, the whole frame is loaded into IN on
// one clock edge, so the OR tree never sees a partial frame. RESULT_LAT edges
// later the tree output is captured into r_data and offered on a valid/ready
// result port. The captured value is also compared against an OR that is
// accumulated locally as the words arrive. Any difference sets a sticky error flag.
//
// Ports:
//   clk      clock; all state changes on the rising edge
//   rst      asynchronous active-high reset
//   s_valid  operand word valid
//   s_ready  packer can accept a word (high only while filling a frame)
//   s_data   operand word, BIT bits
//   IN       packed frame to the OR tree; word k is at IN[k*BIT +: BIT]
//   res_in   output of the OR tree
//   r_valid  captured result available
//   r_ready  result consumer accepts
//   r_data   captured result, BIT bits
//   err      sticky result mismatch flag; only rst clears it

module or_in_packer #(
  parameter int BIT          = 19,
  parameter int NUMBER_INPUT = 8,
  parameter int RESULT_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [BIT-1:0]              s_data,
  output logic [NUMBER_INPUT*BIT-1:0] IN,
  input  logic [BIT-1:0]              res_in,
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [BIT-1:0]              r_data,
  output logic                        err
);

  localparam int IDX_W    = $clog2(NUMBER_INPUT);
  localparam int WCNT_W   = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  // The final word of a frame goes directly into IN, so the shadow holds only N-1 slots.
  localparam int SHADOW_W = (NUMBER_INPUT - 1) * BIT;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUMBER_INPUT - 1);
  localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(RESULT_LAT - 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                      r_state;
  logic [IDX_W-1:0]            r_idx;
  logic [WCNT_W-1:0]           r_wcnt;
  logic [BIT-1:0]              r_acc;
  logic [BIT-1:0]              r_exp;
  logic [SHADOW_W-1:0]         r_shadow;
  logic [NUMBER_INPUT*BIT-1:0] r_in;
  logic                        r_sready;
  logic                        r_rvalid;
  logic [BIT-1:0]              r_rdata;
  logic                        r_err;

  logic w_xfer;
  logic w_last;

  // r_sready is high only in ST_FILL, so a transfer cannot occur in any other state.
  assign w_xfer = s_valid & r_sready;
  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_FILL;
      r_idx    <= '0;
      r_wcnt   <= '0;
      r_acc    <= '0;
      r_exp    <= '0;
      r_shadow <= '0;
      r_in     <= '0;
      r_sready <= 1'b1;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_xfer) begin
            if (w_last) begin
              // Load the whole frame on this edge: the shadow slots plus the word
              // arriving now.
              r_in     <= {s_data, r_shadow};
              r_exp    <= r_acc | s_data;
              r_acc    <= '0;
              r_idx    <= '0;
              r_wcnt   <= '0;
              r_sready <= 1'b0;
              r_state  <= ST_WAIT;
            end else begin
              for (int k = 0; k < NUMBER_INPUT - 1; k++) begin
                if (r_idx == IDX_W'(k)) begin
                  r_shadow[k*BIT +: BIT] <= s_data;
                end
              end
              r_acc <= r_acc | s_data;
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

        ST_WAIT: begin
          // The wait counter starts at 0 on the edge that loads IN. So this
          // capture happens exactly RESULT_LAT edges after that load.
          if (r_wcnt == LAST_WCNT) begin
            r_rdata  <= res_in;
            r_rvalid <= 1'b1;
            if (res_in != r_exp) begin
              r_err <= 1'b1;
            end
            r_state  <= ST_HOLD;
          end else begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
          end
        end

        ST_HOLD: begin
          // s_ready goes high again only after this edge. The next frame
          // therefore cannot start in the same cycle that the result is consumed.
          if (r_ready) begin
            r_rvalid <= 1'b0;
            r_sready <= 1'b1;
            r_state  <= ST_FILL;
          end
        end

        default: begin
          r_state  <= ST_FILL;
          r_idx    <= '0;
          r_acc    <= '0;
          r_sready <= 1'b1;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = r_sready;
  assign IN      = r_in;
  assign r_valid = r_rvalid;
  assign r_data  = r_rdata;
  assign err     = r_err;

endmodule

// File: tb/tb_or_in_packer.sv
// tb/tb_or_in_packer.sv - scoreboard bench for or_in_packer (LAT=1 and LAT=3 instances)

module tb_or_in_packer;

  localparam int BIT  = 19;
  localparam int N    = 8;
  localparam int W    = N * BIT;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst;

  logic           s_valid0, s_valid1;
  logic           s_ready0, s_ready1;
  logic [BIT-1:0] s_data0, s_data1;
  logic [W-1:0]   in0, in1;
  logic [BIT-1:0] res0, res1;
  logic           r_valid0, r_valid1;
  logic           r_ready0, r_ready1;
  logic [BIT-1:0] r_data0, r_data1;
  logic           err0, err1;

  logic           corrupt;
  logic [BIT-1:0] or0, or1;
  logic [BIT-1:0] pipe_a = '0;
  logic [BIT-1:0] pipe_b = '0;

  int             n_checks = 0;
  int             n_errors = 0;
  logic [BIT-1:0] sb_q[$];
  logic [W-1:0]   prev_in[2];
  logic           exp_err[2];
  logic [BIT-1:0] wv[N];

  always #5 clk = ~clk;

  or_in_packer #(.BIT(BIT), .NUMBER_INPUT(N), .RESULT_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
    .IN(in0), .res_in(res0),
    .r_valid(r_valid0), .r_ready(r_ready0), .r_data(r_data0), .err(err0)
  );

  or_in_packer #(.BIT(BIT), .NUMBER_INPUT(N), .RESULT_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .IN(in1), .res_in(res1),
    .r_valid(r_valid1), .r_ready(r_ready1), .r_data(r_data1), .err(err1)
  );

  // OR tree models: the LAT=1 tree is combinational and can be made to drop bit 0.
  // The LAT=3 tree becomes valid two edges after IN changes.
  always_comb begin
    or0 = '0;
    or1 = '0;
    for (int k = 0; k < N; k++) begin
      or0 = or0 | in0[k*BIT +: BIT];
      or1 = or1 | in1[k*BIT +: BIT];
    end
  end
  assign res0 = corrupt ? {or0[BIT-1:1], 1'b0} : or0;
  always @(posedge clk) begin
    pipe_a <= or1;
    pipe_b <= pipe_a;
  end
  assign res1 = pipe_b;

  function automatic logic f_sready(int d);
    return (d == 0) ? s_ready0 : s_ready1;
  endfunction
  function automatic logic f_rvalid(int d);
    return (d == 0) ? r_valid0 : r_valid1;
  endfunction
  function automatic logic [BIT-1:0] f_rdata(int d);
    return (d == 0) ? r_data0 : r_data1;
  endfunction
  function automatic logic f_err(int d);
    return (d == 0) ? err0 : err1;
  endfunction
  function automatic logic [W-1:0] f_in(int d);
    return (d == 0) ? in0 : in1;
  endfunction

  task automatic drive(int d, logic v, logic [BIT-1:0] dat);
    if (d == 0) begin s_valid0 = v; s_data0 = dat; end
    else        begin s_valid1 = v; s_data1 = dat; end
  endtask
  task automatic drive_rr(int d, logic rr);
    if (d == 0) r_ready0 = rr;
    else        r_ready1 = rr;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one word and return 1 ns after the edge that accepts it.
  task automatic send_word(int d, logic [BIT-1:0] w);
    int n = 0;
    drive(d, 1'b1, w);
    while (!f_sready(d) && n < 50) begin
      tick();
      n++;
    end
    chk("s_ready_fill", W'(f_sready(d)), W'(1));
    tick();
    drive(d, 1'b0, '0);
  endtask

  task automatic run_frame(int d, input logic [BIT-1:0] words[N], int gaps, int stall, logic bad);
    logic [BIT-1:0] exp_or;
    logic [BIT-1:0] model;
    logic [W-1:0]   packed_exp;
    int             lat;
    corrupt = bad;
    exp_or  = '0;
    for (int k = 0; k < N; k++) begin
      exp_or = exp_or | words[k];
      packed_exp[k*BIT +: BIT] = words[k];
    end
    model = (d == 0 && bad) ? {exp_or[BIT-1:1], 1'b0} : exp_or;

    for (int k = 0; k < N; k++) begin
      if (gaps > 0) begin
        repeat ($urandom_range(0, gaps)) begin
          drive(d, 1'b0, BIT'($urandom));
          tick();
        end
      end
      if (k == N - 1) chk("in_hold", f_in(d), prev_in[d]);
      send_word(d, words[k]);
    end
    sb_q.push_back(model);
    if (model != exp_or) exp_err[d] = 1'b1;
    chk("in_frame", f_in(d), packed_exp);
    prev_in[d] = packed_exp;
    chk("s_ready_wait", W'(f_sready(d)), W'(0));

    lat = 0;
    while (!f_rvalid(d) && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", W'(lat), W'((d == 0) ? LAT0 : LAT1));
    chk("r_data", W'(f_rdata(d)), W'(sb_q.pop_front()));
    chk("err", W'(f_err(d)), W'(exp_err[d]));

    // While the result is stalled, keep a word offered; the packer must not take it.
    for (int i = 0; i < stall; i++) begin
      drive(d, 1'b1, 19'h5A5A5);
      tick();
      chk("stall_r_valid", W'(f_rvalid(d)), W'(1));
      chk("stall_r_data", W'(f_rdata(d)), W'(model));
      chk("stall_s_ready", W'(f_sready(d)), W'(0));
    end
    drive(d, 1'b0, '0);
    drive_rr(d, 1'b1);
    tick();
    drive_rr(d, 1'b0);
    chk("r_valid_clr", W'(f_rvalid(d)), W'(0));
    chk("s_ready_back", W'(f_sready(d)), W'(1));
  endtask

  task automatic rand_words;
    for (int k = 0; k < N; k++) wv[k] = BIT'($urandom % ((2**BIT) - 1));
  endtask

  initial begin
    rst = 1'b1;
    corrupt = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    drive_rr(0, 1'b0);
    drive_rr(1, 1'b0);
    prev_in[0] = '0;
    prev_in[1] = '0;
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_in", f_in(d), '0);
      chk("rst_s_ready", W'(f_sready(d)), W'(1));
      chk("rst_r_valid", W'(f_rvalid(d)), W'(0));
      chk("rst_r_data", W'(f_rdata(d)), W'(0));
      chk("rst_err", W'(f_err(d)), W'(0));
    end
    rst = 1'b0;
    tick();

    // Basic frame: walking ones, back to back.
    for (int k = 0; k < N; k++) wv[k] = BIT'(1 << k);
    run_frame(0, wv, 0, 0, 1'b0);

    // Random gaps between words.
    for (int k = 0; k < N; k++) wv[k] = '0;
    wv[0] = 19'h7FFFF;
    run_frame(0, wv, 3, 0, 1'b0);

    // Result backpressure, then a frame showing the stalled word was not consumed.
    rand_words();
    run_frame(0, wv, 0, 10, 1'b0);
    rand_words();
    run_frame(0, wv, 2, 0, 1'b0);

    // Mismatch: the tree drops bit 0. err then stays set over later good frames.
    for (int k = 0; k < N; k++) wv[k] = BIT'(1 << k);
    run_frame(0, wv, 0, 0, 1'b1);
    rand_words();
    run_frame(0, wv, 1, 0, 1'b0);
    rand_words();
    run_frame(0, wv, 0, 3, 1'b0);

    // Reset after 3 words of a frame.
    send_word(0, 19'h00011);
    send_word(0, 19'h00022);
    send_word(0, 19'h00044);
    rst = 1'b1;
    #1;
    chk("midrst_in", in0, '0);
    chk("midrst_s_ready", W'(s_ready0), W'(1));
    chk("midrst_r_valid", W'(r_valid0), W'(0));
    chk("midrst_err", W'(err0), W'(0));
    chk("midrst_r_data", W'(r_data0), W'(0));
    prev_in[0] = '0;
    prev_in[1] = '0;
    exp_err[0] = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rand_words();
    run_frame(0, wv, 0, 0, 1'b0);

    // Latency 3 sweep over random frames.
    for (int f = 0; f < 100; f++) begin
      rand_words();
      run_frame(1, wv, 2, $urandom_range(0, 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/or_in_packer.md
Name: or_in_packer

Overview:
- Initiator-side front end for the OR-base reduction datapath.
- Accepts operands one BIT-wide word per cycle over a valid/ready stream and packs NUMBER_INPUT words into the wide IN bus the OR tree consumes.
- Launches IN atomically, samples the tree's out after a fixed latency, and returns the result on a valid/ready result port.
- Checks the returned result against an internally accumulated OR and flags mismatches.

Parameters:
BIT, 19, width of each operand word and of the result
NUMBER_INPUT, 8, words per frame (>=2)
RESULT_LAT, 1, cycles from IN update to a valid DUT out (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
s_valid  input  1  operand word valid
s_ready  output  1  packer can accept a word
s_data  input  BIT  operand word
IN  output  NUMBER_INPUT*BIT  packed operand bus to OR tree; word k at IN[k*BIT +: BIT]
res_in  input  BIT  out of OR tree
r_valid  output  1  result available
r_ready  input  1  result consumer accepts
r_data  output  BIT  captured result
err  output  1  sticky mismatch flag

Behaviour:
- Reset (asynchronous, active-high): state=FILL, idx=0, acc=0, shadow=0, IN=0, r_valid=0, r_data=0, err=0. s_ready is 1 out of reset.
- States: FILL, WAIT, HOLD.
- FILL:
  - s_ready=1.
  - Transfer happens when s_valid&&s_ready at a rising edge.
  - On a transfer with idx<NUMBER_INPUT-1: shadow slot idx<=s_data, acc<=acc|s_data, idx++.
  - On the transfer with idx==NUMBER_INPUT-1: IN<=shadow with slot N-1 replaced by s_data, all in one edge. exp<=acc|s_data, acc<=0, idx<=0, wcnt<=0, go to WAIT.
  - IN never shows a partially filled frame. IN holds the previous frame throughout FILL.
- WAIT:
  - s_ready=0.
  - wcnt increments each cycle.
  - At the edge where wcnt==RESULT_LAT-1: r_data<=res_in, r_valid<=1, go to HOLD.
  - At that same edge, if res_in!=exp then err<=1.
  - Net timing: the result is sampled exactly RESULT_LAT edges after the edge that loaded IN.
- HOLD:
  - s_ready=0. r_valid=1; r_data stable.
  - On r_ready: r_valid<=0, go to FILL.
  - The next frame's first word is accepted no earlier than the following edge; there is no overlap between frames.
- IN, r_data and exp change only as stated above; IN persists until the next frame completes.
- s_data is ignored when s_valid=0 or s_ready=0.
- err is sticky and cleared only by rst.
- Width: acc, exp, r_data are BIT wide; all operations are bitwise; no arithmetic overflow possible.
- idx width is clog2(NUMBER_INPUT); wrap from N-1 to 0 happens only on the final transfer.
- Reset mid-operation (any state):
  - Frame is discarded; all registers return to reset values; IN drops to 0 immediately.
  - A pending r_valid is lost.
- s_valid held high continuously in FILL: exactly one word per cycle, a frame completes in N cycles.
- Latency: last word edge -> r_valid high after RESULT_LAT edges.
- Throughput: one frame per N+RESULT_LAT+1 cycles minimum, with r_ready tied high.

Test Plan:
- Reset: assert rst mid-frame after 3 words -> IN=0, s_ready=1, r_valid=0, err=0; next frame starts at slot 0.
- Basic pack (BIT=19, N=8, LAT=1): s_data=0x00001,0x00002,...,0x00080 back-to-back.
  - IN slot k = 1<<k after the 8th edge.
  - Ideal OR model on res_in -> r_data=0x000FF one edge later, err=0.
- Stall/gaps: drop s_valid randomly between words.
  - IN is unchanged until the 8th transfer.
  - r_data correct for words 0x7FFFF,0,0,...,0 -> 0x7FFFF.
- Result backpressure: hold r_ready=0 for 10 cycles.
  - r_valid and r_data stay stable; s_ready stays 0.
  - s_valid words offered during the stall are not consumed.
  - After the r_ready pulse, s_ready=1 on the next cycle.
- Mismatch: model returns 0x000FE instead of 0x000FF -> err=1 and stays 1 over subsequent correct frames until rst.
- Latency sweep: RESULT_LAT=3 with a 3-cycle-delayed model -> r_data matches exp, err=0, over 100 random frames of words drawn from {$random} % (2^19-1).
